isplata_kusura: RTL and testbench

//  Change-payout responder for the candy-vending FSM. Accepts one change request
//  (amount in dinars) over a valid/ready handshake. Pays it out greedily as timed

---
 rtl/isplata_pkg.sv | 44 ++++
 rtl/isplata_kusura_seg7_dek.sv | 31 +++
 rtl/isplata_kusura.sv | 132 +++++++++++++
 tb/tb_isplata_kusura.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/isplata_pkg.sv
// isplata_pkg
//   Shared constants for the change-payout responder: FSM state encoding,
//   coin denominations, the largest payable amount and active-low 7-segment
//   patterns. Also holds the helpers that turn a raw request into the amount
//   actually paid and the error flag.
//   No ports (package).
package isplata_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [4:0] COIN5      = 5'd5;
  localparam logic [4:0] COIN10     = 5'd10;
  localparam logic [4:0] MAX_AMOUNT = 5'd30;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Over-range requests saturate to the maximum; otherwise the odd dinars
  // that no coin can cover are dropped.
  function automatic logic [4:0] payAmount(input logic [4:0] amount);
    if (amount > MAX_AMOUNT) begin
      return MAX_AMOUNT;
    end
    return amount - (amount % 5'd5);
  endfunction

  function automatic logic amountErr(input logic [4:0] amount);
    return (amount > MAX_AMOUNT) || ((amount % 5'd5) != 5'd0);
  endfunction

endpackage

// File: rtl/isplata_kusura_seg7_dek.sv
// seg7_dek
//   Decodes one BCD digit to an active-low 7-segment pattern. Codes above 9
//   blank the digit.
//   Ports:
//     digit_i  in  4  BCD digit 0..9
//     seg_o    out 7  active-low segments {g,f,e,d,c,b,a}
module seg7_dek
  import isplata_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/isplata_kusura.sv
// isplata_kusura
//   Change-payout responder. Accepts one change request over valid/ready,
//   pays it out greedily as timed coin-ejector pulses (10 before 5), shows
//   the unpaid remainder on two 7-seg digits and strobes done (with err when
//   the amount could not be paid exactly).
//   Ports:
//     CLOCK_50    in   1  clock, all state changes on posedge
//     RST         in   1  synchronous active-high reset
//     req_valid   in   1  change request present
//     req_amount  in   5  change in dinars
//     req_ready   out  1  idle, request accepted this cycle if valid
//     coin10      out  1  10-dinar ejector drive
//     coin5       out  1  5-dinar ejector drive
//     busy        out  1  payout in progress
//     done        out  1  one-cycle completion strobe
//     err         out  1  with done: amount was not a payable multiple of 5
//     remaining   out  5  unpaid change in dinars
//     HEX_ONES    out  7  active-low ones digit of remaining
//     HEX_TENS    out  7  active-low tens digit of remaining
module isplata_kusura
  import isplata_pkg::*;
#(
  parameter int PULSE_CYCLES = 50_000_000,
  parameter int GAP_CYCLES   = 25_000_000,
  parameter int CNT_W        = 26
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       req_valid,
  input  logic [4:0] req_amount,
  output logic       req_ready,
  output logic       coin10,
  output logic       coin5,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] remaining,
  output logic [6:0] HEX_ONES,
  output logic [6:0] HEX_TENS
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rem_q, rem_d;
  logic             errPend_q, errPend_d;
  logic [4:0]       loadAmount;
  logic [4:0]       coinValue;
  logic [3:0]       onesDigit, tensDigit;

  assign loadAmount = payAmount(req_amount);

  // remaining is frozen for the whole pulse, so deciding the coin from it
  // gives a selection that is fixed on entry to PULSE.
  assign coinValue = (rem_q >= COIN10) ? COIN10 : COIN5;

  // The counter restarts on every state change so each state times itself.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    rem_d     = rem_q;
    errPend_d = errPend_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          rem_d     = loadAmount;
          errPend_d = amountErr(req_amount);
          state_d   = (loadAmount != 5'd0) ? S_PULSE : S_DONE;
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          rem_d   = rem_q - coinValue;
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = (rem_q != 5'd0) ? S_PULSE : S_DONE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        errPend_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= 5'd0;
      errPend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      errPend_q <= errPend_d;
    end
  end

  // Every control output decodes registers only, so nothing on req_* can
  // ripple through to the ejectors or the handshake.
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && errPend_q;
  assign coin10    = (state_q == S_PULSE) && (rem_q >= COIN10);
  assign coin5     = (state_q == S_PULSE) && (rem_q < COIN10);
  assign remaining = rem_q;

  assign tensDigit = 4'(rem_q / 5'd10);
  assign onesDigit = 4'(rem_q % 5'd10);

  seg7_dek uOnes (
    .digit_i (onesDigit),
    .seg_o   (HEX_ONES)
  );

  seg7_dek uTens (
    .digit_i (tensDigit),
    .seg_o   (HEX_TENS)
  );

endmodule

// File: tb/tb_isplata_kusura.sv
module tb_isplata_kusura;

  localparam int P = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reqValid = 1'b0;
  logic [4:0] reqAmount = 5'd0;
  logic       reqReady, coin10, coin5, busy, done, err;
  logic [4:0] remaining;
  logic [6:0] hexOnes, hexTens;

  int total = 0;
  int bad = 0;

  // Reference digit patterns, active-low {g,f,e,d,c,b,a}.
  logic [6:0] segTable [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                7'b0110000, 7'b0011001, 7'b0010010,
                                7'b0000010, 7'b1111000, 7'b0000000,
                                7'b0010000};

  isplata_kusura #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
    .CNT_W        (8)
  ) dut (
    .CLOCK_50   (clk),
    .RST        (rst),
    .req_valid  (reqValid),
    .req_amount (reqAmount),
    .req_ready  (reqReady),
    .coin10     (coin10),
    .coin5      (coin5),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .remaining  (remaining),
    .HEX_ONES   (hexOnes),
    .HEX_TENS   (hexTens)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from idle and checks every cycle until ready returns.
  // mode 0: valid low during payout; 1: random valid/amount noise while busy;
  // 2: requester raises valid with 5 from cycle 3 and holds it.
  task automatic runPayout(input int amount, input int mode, input string tag);
    int pay;
    bit errExp;
    int coins[$];
    int n, doneCycle, expRem, k, off;
    logic [5:0] expCtrl, gotCtrl;
    logic expC10, expC5;
    pay = (amount > 30) ? 30 : amount - (amount % 5);
    errExp = (amount > 30) || (amount % 5 != 0);
    for (int t = 0; t < pay / 10; t++) coins.push_back(10);
    if (pay % 10 == 5) coins.push_back(5);
    n = coins.size();
    doneCycle = n * (P + G) + 1;
    reqValid = 1'b1;
    reqAmount = 5'(amount);
    stepCycle();
    for (int c = 1; c <= doneCycle + 1; c++) begin
      if (c > doneCycle || mode == 0) begin
        reqValid = 1'b0;
      end else if (mode == 1) begin
        reqValid = 1'($urandom_range(0, 1));
        reqAmount = 5'($urandom);
      end else begin
        reqValid = (c >= 3);
        reqAmount = 5'd5;
      end
      k = (c - 1) / (P + G);
      off = (c - 1) % (P + G);
      expC10 = (k < n) && (off < P) && (coins[k] == 10);
      expC5 = (k < n) && (off < P) && (coins[k] == 5);
      expRem = pay;
      for (int j = 0; j < n; j++) begin
        if (j * (P + G) + P <= c - 1) expRem -= coins[j];
      end
      expCtrl = {expC10, expC5, c == doneCycle, (c == doneCycle) && errExp,
                 c <= doneCycle, c == doneCycle + 1};
      gotCtrl = {coin10, coin5, done, err, busy, reqReady};
      total++;
      if (gotCtrl !== expCtrl) begin
        bad++;
        $display("[TB] FAIL %s ctrl cycle %0d: got %b want %b (c10,c5,done,err,busy,ready)",
                 tag, c, gotCtrl, expCtrl);
      end
      total++;
      if (remaining !== 5'(expRem)) begin
        bad++;
        $display("[TB] FAIL %s remaining cycle %0d: got %0d want %0d", tag, c, remaining, expRem);
      end
      total++;
      if ({hexTens, hexOnes} !== {segTable[expRem / 10], segTable[expRem % 10]}) begin
        bad++;
        $display("[TB] FAIL %s hex cycle %0d: got %b_%b want %b_%b", tag, c, hexTens, hexOnes,
                 segTable[expRem / 10], segTable[expRem % 10]);
      end
      stepCycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reqValid = 1'b0;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    stepCycle();
    total++;
    if (remaining !== 5'd0) begin
      bad++;
      $display("[TB] FAIL reset remaining: got %0d want 0", remaining);
    end
    total++;
    if (hexOnes !== 7'b1000000 || hexTens !== 7'b1000000) begin
      bad++;
      $display("[TB] FAIL reset hex: got %b_%b want 1000000_1000000", hexTens, hexOnes);
    end
    total++;
    if ({coin10, coin5, done, err, busy, reqReady} !== 6'b000001) begin
      bad++;
      $display("[TB] FAIL reset ctrl: got %b want 000001",
               {coin10, coin5, done, err, busy, reqReady});
    end
  endtask

  task automatic test_basic();
    runPayout(15, 0, "basic15");
  endtask

  task automatic test_zero();
    runPayout(0, 0, "zero");
  endtask

  task automatic test_err17();
    runPayout(17, 0, "err17");
    runPayout(31, 0, "sat31");
  endtask

  task automatic test_ignore_busy();
    runPayout(30, 2, "ignore30");
  endtask

  task automatic test_reset_mid();
    bit sawBad;
    reqValid = 1'b1;
    reqAmount = 5'd20;
    stepCycle();
    reqValid = 1'b0;
    for (int c = 1; c < 5; c++) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    total++;
    if ({coin10, coin5, done, err, busy, reqReady} !== 6'b000001 || remaining !== 5'd0) begin
      bad++;
      $display("[TB] FAIL midreset state: got ctrl %b rem %0d want ctrl 000001 rem 0",
               {coin10, coin5, done, err, busy, reqReady}, remaining);
    end
    sawBad = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (done !== 1'b0 || coin10 !== 1'b0 || coin5 !== 1'b0) sawBad = 1'b1;
      stepCycle();
    end
    total++;
    if (sawBad) begin
      bad++;
      $display("[TB] FAIL midreset quiet: got activity 1 want 0");
    end
    runPayout(5, 0, "after_reset5");
  endtask

  task automatic test_random();
    for (int i = 0; i < 14; i++) begin
      runPayout(int'($urandom_range(0, 31)), 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_err17();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
